// File: rtl/next_pc_unit.sv
// Fetch PC generator with a one-deep delayed-redirect buffer (keeps the delay slot intact).
// Define NEXT_PC_RAS_EN to build the return-address stack; otherwise RAS outputs are tied to zero.
module next_pc_unit #(
    parameter int unsigned ADDR_W       = 32,
    parameter logic [63:0] RESET_VECTOR = 64'hBFC00000,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       Instruction,
    input  logic [ADDR_W-1:0] Instr_PC_Plus4,
    input  logic              Decode_Valid,
    input  logic              Jump,
    input  logic              JumpRegister,
    input  logic              Branch,
    input  logic              BranchTaken,
    input  logic              Link,
    input  logic [4:0]        Register,
    input  logic [ADDR_W-1:0] RegisterValue,
    input  logic              FWD_REQ_FREEZE,
    input  logic              IMEM_READY,
    output logic [ADDR_W-1:0] PC,
    output logic              RedirectPending,
    output logic              RedirectOverrun,
    output logic [ADDR_W-1:0] RAS_Top,
    output logic              RAS_Valid,
    output logic              RAS_Mispredict
);

    typedef enum logic {StNormal, StPending} state_e;

    localparam logic [ADDR_W-1:0] ResetPc = RESET_VECTOR[ADDR_W-1:0];

    state_e            stateQ;
    logic [ADDR_W-1:0] pcQ;
    logic [ADDR_W-1:0] pendingTargetQ;
    logic              overrunQ;
    logic              fadv;
    logic              rev;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] branchOffset;
    logic              unusedBits;

    assign fadv = IMEM_READY & ~FWD_REQ_FREEZE;
    assign rev  = Decode_Valid & ~FWD_REQ_FREEZE & (Jump | (Branch & BranchTaken));

    assign branchOffset = {{(ADDR_W - 18){Instruction[15]}}, Instruction[15:0], 2'b00};
    assign unusedBits   = ^Instruction[31:26];

    always_comb begin
        target = Instr_PC_Plus4 + branchOffset;
        if (Jump && JumpRegister) begin
            target = RegisterValue;
        end else if (Jump) begin
            target = {Instr_PC_Plus4[ADDR_W-1:28], Instruction[25:0], 2'b00};
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stateQ         <= StNormal;
            pcQ            <= ResetPc;
            pendingTargetQ <= '0;
            overrunQ       <= 1'b0;
        end else begin
            overrunQ <= rev && (stateQ == StPending);
            unique case (stateQ)
                StNormal: begin
                    if (rev && fadv) begin
                        pcQ <= target;
                    end else if (rev) begin
                        pendingTargetQ <= target;
                        stateQ         <= StPending;
                    end else if (fadv) begin
                        pcQ <= pcQ + ADDR_W'(4);
                    end
                end
                StPending: begin
                    // A newer redirect always supersedes the buffered one.
                    if (rev && fadv) begin
                        pcQ    <= target;
                        stateQ <= StNormal;
                    end else if (rev) begin
                        pendingTargetQ <= target;
                    end else if (fadv) begin
                        pcQ    <= pendingTargetQ;
                        stateQ <= StNormal;
                    end
                end
                default: stateQ <= StNormal;
            endcase
        end
    end

    assign PC              = pcQ;
    assign RedirectPending = (stateQ == StPending);
    assign RedirectOverrun = overrunQ;

`ifdef NEXT_PC_RAS_EN
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] rasMem [RAS_DEPTH];
    logic [PtrW-1:0]   rasPtr;
    logic [PtrW-1:0]   ptrInc;
    logic [PtrW-1:0]   ptrDec;
    logic [CntW-1:0]   rasCnt;
    logic              mispredictQ;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] pushVal;

    assign push    = rev & Link;
    assign pop     = rev & JumpRegister & (Register == 5'd31);
    assign pushVal = Instr_PC_Plus4 + ADDR_W'(4);
    assign ptrInc  = (rasPtr == PtrW'(RAS_DEPTH - 1)) ? '0 : rasPtr + PtrW'(1);
    assign ptrDec  = (rasPtr == '0) ? PtrW'(RAS_DEPTH - 1) : rasPtr - PtrW'(1);

    // rasPtr is the next write slot; the top entry sits just below it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rasPtr      <= '0;
            rasCnt      <= '0;
            mispredictQ <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                rasMem[i] <= '0;
            end
        end else begin
            mispredictQ <= pop && (rasCnt != '0) && (RAS_Top != RegisterValue);
            if (push && pop && (rasCnt != '0)) begin
                rasMem[ptrDec] <= pushVal;
            end else if (push) begin
                // Full stack: the slot at rasPtr holds the oldest entry and is overwritten.
                rasMem[rasPtr] <= pushVal;
                rasPtr         <= ptrInc;
                if (rasCnt != CntW'(RAS_DEPTH)) begin
                    rasCnt <= rasCnt + CntW'(1);
                end
            end else if (pop && (rasCnt != '0)) begin
                rasPtr <= ptrDec;
                rasCnt <= rasCnt - CntW'(1);
            end
        end
    end

    assign RAS_Valid      = (rasCnt != '0);
    assign RAS_Top        = RAS_Valid ? rasMem[ptrDec] : '0;
    assign RAS_Mispredict = mispredictQ;
`else
    logic unusedRas;

    assign unusedRas      = ^{Link, Register};
    assign RAS_Top        = '0;
    assign RAS_Valid      = 1'b0;
    assign RAS_Mispredict = 1'b0;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Randomized bench for next_pc_unit against a queue-based reference model, plus directed scenarios.
// Define NEXT_PC_RAS_EN for both DUT and bench to exercise the return-address stack.
module tb_next_pc_unit;

    localparam int unsigned Depth = 4;

    logic        CLK;
    logic        RESET;
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic        decValid;
    logic        jump;
    logic        jumpReg;
    logic        branch;
    logic        taken;
    logic        link;
    logic [4:0]  regNum;
    logic [31:0] regVal;
    logic        freeze;
    logic        imemReady;
    logic [31:0] pcOut;
    logic        pendingOut;
    logic        overrunOut;
    logic [31:0] rasTopOut;
    logic        rasValidOut;
    logic        mispredictOut;

    // Reference model state
    logic [31:0] mPc;
    logic        mPending;
    logic [31:0] mTarget;
    logic [31:0] ras[$];
    logic        expOverrun;
    logic        expMispred;

    int nChecks = 0;
    int nPass   = 0;

    next_pc_unit #(
        .ADDR_W      (32),
        .RESET_VECTOR(64'hBFC00000),
        .RAS_DEPTH   (Depth)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .Instruction    (instr),
        .Instr_PC_Plus4 (pcPlus4),
        .Decode_Valid   (decValid),
        .Jump           (jump),
        .JumpRegister   (jumpReg),
        .Branch         (branch),
        .BranchTaken    (taken),
        .Link           (link),
        .Register       (regNum),
        .RegisterValue  (regVal),
        .FWD_REQ_FREEZE (freeze),
        .IMEM_READY     (imemReady),
        .PC             (pcOut),
        .RedirectPending(pendingOut),
        .RedirectOverrun(overrunOut),
        .RAS_Top        (rasTopOut),
        .RAS_Valid      (rasValidOut),
        .RAS_Mispredict (mispredictOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("pc", pcOut, mPc);
        check("pending", 32'(pendingOut), 32'(mPending));
        check("overrun", 32'(overrunOut), 32'(expOverrun));
        check("rasTop", rasTopOut, (ras.size() > 0) ? ras[$] : 32'd0);
        check("rasValid", 32'(rasValidOut), 32'(ras.size() > 0));
        check("mispredict", 32'(mispredictOut), 32'(expMispred));
    endtask

    task automatic model_reset();
        mPc        = 32'hBFC00000;
        mPending   = 1'b0;
        mTarget    = 32'd0;
        expOverrun = 1'b0;
        expMispred = 1'b0;
        ras.delete();
    endtask

    task automatic set_idle();
        decValid = 1'b0;
        jump     = 1'b0;
        jumpReg  = 1'b0;
        branch   = 1'b0;
        taken    = 1'b0;
        link     = 1'b0;
        regNum   = 5'd0;
        regVal   = 32'd0;
        instr    = 32'd0;
        pcPlus4  = 32'd0;
        freeze   = 1'b0;
    endtask

    function automatic logic [31:0] target_of();
        int off;
        if (jump && jumpReg) return regVal;
        if (jump) return {pcPlus4[31:28], instr[25:0], 2'b00};
        off = int'($signed(instr[15:0])) * 4;
        return pcPlus4 + 32'(off);
    endfunction

    // Apply the current inputs for one clock, advance the model, then compare.
    task automatic step();
        logic        fadv;
        logic        rev;
        logic [31:0] tgt;
        fadv       = imemReady && !freeze;
        rev        = decValid && !freeze && (jump || (branch && taken));
        tgt        = target_of();
        expOverrun = rev && mPending;
        expMispred = 1'b0;
`ifdef NEXT_PC_RAS_EN
        if (rev) begin
            if (jumpReg && (regNum == 5'd31) && (ras.size() > 0)) begin
                expMispred = (ras[$] != regVal);
                void'(ras.pop_back());
            end
            if (link) begin
                ras.push_back(pcPlus4 + 32'd4);
                if (ras.size() > Depth) void'(ras.pop_front());
            end
        end
`endif
        if (rev) begin
            if (fadv) begin
                mPc      = tgt;
                mPending = 1'b0;
            end else begin
                mTarget  = tgt;
                mPending = 1'b1;
            end
        end else if (fadv) begin
            if (mPending) begin
                mPc      = mTarget;
                mPending = 1'b0;
            end else begin
                mPc = mPc + 32'd4;
            end
        end
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [31:0] held;
        RESET     = 1'b0;
        imemReady = 1'b1;
        set_idle();
        model_reset();
        #12;
        check_outputs();
        RESET = 1'b1;

        // Sequential fetch out of reset
        repeat (3) step();
        check("seqPc", pcOut, 32'hBFC0000C);

        // Taken branch with negative offset
        decValid = 1'b1; branch = 1'b1; taken = 1'b1;
        pcPlus4  = 32'h00400010; instr = 32'h1000FFFF;
        step();
        check("branchPc", pcOut, 32'h0040000C);

        // j while fetch is stalled: redirect stays pending for two cycles
        set_idle();
        imemReady = 1'b0;
        decValid  = 1'b1; jump = 1'b1;
        pcPlus4   = 32'h90000010; instr = 32'h08100000;
        step();
        check("jPend1", 32'(pendingOut), 32'd1);
        set_idle();
        step();
        check("jPend2", 32'(pendingOut), 32'd1);
        imemReady = 1'b1;
        step();
        check("jPc", pcOut, 32'h90400000);
        check("jPendClr", 32'(pendingOut), 32'd0);

        // jr held in decode while frozen: applied once after unfreeze
        held     = mPc;
        decValid = 1'b1; jump = 1'b1; jumpReg = 1'b1;
        regNum   = 5'd4; regVal = 32'h00401000; freeze = 1'b1;
        repeat (3) begin
            step();
            check("freezeHold", pcOut, held);
        end
        freeze = 1'b0;
        step();
        check("jrPc", pcOut, 32'h00401000);
        set_idle();
        step();
        check("jrOnce", pcOut, 32'h00401004);

        // Reset while a redirect is pending discards it immediately
        imemReady = 1'b0;
        decValid  = 1'b1; jump = 1'b1; instr = 32'h08000040; pcPlus4 = 32'h00400000;
        step();
        set_idle();
        RESET = 1'b0;
        #2;
        model_reset();
        check_outputs();
        check("rstPend", 32'(pendingOut), 32'd0);
        #1;
        RESET     = 1'b1;
        imemReady = 1'b1;
        step();

`ifdef NEXT_PC_RAS_EN
        // jal then matching jr $31
        decValid = 1'b1; jump = 1'b1; link = 1'b1; pcPlus4 = 32'h00400104;
        step();
        check("jalTop", rasTopOut, 32'h00400108);
        set_idle();
        decValid = 1'b1; jump = 1'b1; jumpReg = 1'b1; regNum = 5'd31; regVal = 32'h00400108;
        step();
        check("jrNoMisp", 32'(mispredictOut), 32'd0);
        check("jrEmpty", 32'(rasValidOut), 32'd0);

        // Overflow by one, then drain in LIFO order
        for (int i = 0; i < 5; i++) begin
            set_idle();
            decValid = 1'b1; jump = 1'b1; link = 1'b1; pcPlus4 = 32'h00500000 + 32'(i * 16);
            step();
        end
        for (int i = 4; i >= 0; i--) begin
            set_idle();
            if (i > 0) check("lifoTop", rasTopOut, 32'h00500004 + 32'(i * 16));
            decValid = 1'b1; jump = 1'b1; jumpReg = 1'b1; regNum = 5'd31;
            regVal   = 32'h00500004 + 32'(i * 16);
            step();
        end
        check("drained", 32'(rasValidOut), 32'd0);
        set_idle();
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            decValid  = ($urandom_range(0, 3) != 0);
            jump      = ($urandom_range(0, 2) == 0);
            jumpReg   = jump && ($urandom_range(0, 1) == 1);
            branch    = !jump && ($urandom_range(0, 1) == 1);
            taken     = ($urandom_range(0, 1) == 1);
            link      = jump && ($urandom_range(0, 2) == 0);
            regNum    = ($urandom_range(0, 2) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            regVal    = ((ras.size() > 0) && ($urandom_range(0, 1) == 1)) ? ras[$] : $urandom;
            instr     = $urandom;
            pcPlus4   = $urandom & 32'hFFFFFFFC;
            freeze    = ($urandom_range(0, 4) == 0);
            imemReady = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
